// File: rtl/seq_pkg.sv
// Shared definitions for the 1010 sequence path (serializer and detector variants).
//   ser_state_e   : serializer FSM state encoding (SER_IDLE / SER_SHIFT)
//   SER_IDLE_BIT  : default filler value on the serial line when no word is in flight
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bundle of the serializer.
//   din, din_valid, din_ready : parallel word handshake
//   x, x_valid, x_last        : registered serial output towards the detector
//   state                     : serializer FSM state, observable for checkers
//
// Handshake: a word moves on a rising clk edge where din_valid and din_ready
// are both 1. The producer holds din stable while din_valid=1 and din_ready=0.
// din_ready depends on serializer registers only, never on din_valid.
//
// Modports: master = word producer, slave = serializer.
interface seq_bit_serializer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             x_last;
  ser_state_e       state;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, x_last, state
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, x_last, state
  );

endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1010 sequence detector.
// Accepts WIDTH-bit words and emits them one bit per clock on x. Consecutive
// words stream with no idle gap, so patterns spanning word boundaries survive.
// While no word is in flight x holds IDLE_BIT and x_valid is 0.
//
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset; discards any partially sent word
//   bus    : seq_bit_serializer_if.slave (din/din_valid/din_ready in,
//            x/x_valid/x_last/state out)
//
// Parameters:
//   WIDTH     : bits per word (>= 1)
//   MSB_FIRST : 1 sends din[WIDTH-1] first, 0 sends din[0] first
//   IDLE_BIT  : value on x while idle or in reset
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_bit_serializer_if.slave  bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic          ONE_BIT  = (WIDTH == 1);

  ser_state_e       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             x_r;
  logic             x_valid_r;
  logic             x_last_r;

  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] load_sreg;
  logic             next_bit;
  logic [WIDTH-1:0] next_sreg;

  // Ready only in IDLE or while the last bit of the current word is on x;
  // that last-bit accept is what gives zero-gap streaming.
  assign bus.din_ready = (state == SER_IDLE) ||
                         ((state == SER_SHIFT) && (cnt == CNT_LAST));
  assign accept        = bus.din_valid && bus.din_ready;

  // The first bit goes straight to x on load, so the shift register keeps
  // the word pre-shifted by one; the outgoing end always holds the next bit.
  assign first_bit = (MSB_FIRST != 0) ? bus.din[WIDTH-1] : bus.din[0];
  assign load_sreg = (MSB_FIRST != 0) ? (bus.din << 1) : (bus.din >> 1);
  assign next_bit  = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  assign next_sreg = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SER_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      x_r       <= IDLE_BIT;
      x_valid_r <= 1'b0;
      x_last_r  <= 1'b0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (accept) begin
            state     <= SER_SHIFT;
            sreg      <= load_sreg;
            cnt       <= '0;
            x_r       <= first_bit;
            x_valid_r <= 1'b1;
            x_last_r  <= ONE_BIT;
          end else begin
            x_r       <= IDLE_BIT;
            x_valid_r <= 1'b0;
            x_last_r  <= 1'b0;
          end
        end
        SER_SHIFT: begin
          if (cnt != CNT_LAST) begin
            sreg     <= next_sreg;
            cnt      <= cnt + 1'b1;
            x_r      <= next_bit;
            x_last_r <= ((cnt + 1'b1) == CNT_LAST);
          end else if (accept) begin
            sreg      <= load_sreg;
            cnt       <= '0;
            x_r       <= first_bit;
            x_valid_r <= 1'b1;
            x_last_r  <= ONE_BIT;
          end else begin
            state     <= SER_IDLE;
            cnt       <= '0;
            x_r       <= IDLE_BIT;
            x_valid_r <= 1'b0;
            x_last_r  <= 1'b0;
          end
        end
        default: begin
          state     <= SER_IDLE;
          cnt       <= '0;
          x_r       <= IDLE_BIT;
          x_valid_r <= 1'b0;
          x_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x       = x_r;
  assign bus.x_valid = x_valid_r;
  assign bus.x_last  = x_last_r;
  assign bus.state   = state;

endmodule
